// File: rtl/axi_lite_imem_slave_pkg.sv
// Shared types and defaults for the AXI4-Lite instruction-memory read responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_lite_imem_slave_pkg;

  // AXI read response codes.
  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  // Responder state encoding.
  typedef enum logic [1:0] {
    IMEM_S_IDLE = 2'd0,
    IMEM_S_WAIT = 2'd1,
    IMEM_S_RESP = 2'd2
  } imem_state_e;

  // Default decodable window: 128 MiB starting at 0x8000_0000.
  localparam logic [31:0] IMEM_DEF_MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] IMEM_DEF_MEM_SIZE = 32'h0800_0000;

  // Only OKAY requests touch the backing store.
  function automatic logic resp_is_okay(input axi_resp_e r);
    return (r == AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_lite_imem_slave.sv
// AXI4-Lite read responder serving instruction fetches from a backing store.
// Latency: AR handshake at edge E -> rvalid after edge E+LATENCY; one request in flight.
// Backpressure: arready low outside IDLE; R beat held stable until rready.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   araddr/arvalid/arready   AR channel (slave side)
//   rdata/rresp/rvalid/rready R channel (slave side)
//   mem_r_en/mem_addr/mem_r_data  backing-store read port (data combinational)
module axi_lite_imem_slave
  import axi_lite_imem_slave_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       LATENCY  = 1,
  parameter logic [ADDR_W-1:0] MEM_BASE = IMEM_DEF_MEM_BASE,
  parameter logic [ADDR_W-1:0] MEM_SIZE = IMEM_DEF_MEM_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_r_data
);

  // Window bounds carried one bit wider so BASE+SIZE at the top of the
  // address space does not wrap to a small value.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [ADDR_W:0] WIN_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  localparam logic [7:0]      CNT_LOAD = 8'(LATENCY - 1);

  imem_state_e       state_q,   state_d;
  logic [7:0]        cnt_q,     cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  axi_resp_e         class_q,   class_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  axi_resp_e         rresp_q,   rresp_d;
  logic              rvalid_q,  rvalid_d;
  logic              arready_q, arready_d;

  axi_resp_e         ar_class;
  logic [ADDR_W:0]   araddr_x;

  // Error class of the address currently on the AR channel.
  always_comb begin
    araddr_x = {1'b0, araddr};
    ar_class = AXI_RESP_OKAY;
    if (araddr[1:0] != 2'b00) begin
      ar_class = AXI_RESP_SLVERR;
    end else if ((araddr_x < WIN_LO) || (araddr_x >= WIN_HI)) begin
      ar_class = AXI_RESP_DECERR;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    class_d  = class_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    mem_r_en = 1'b0;

    case (state_q)
      IMEM_S_IDLE: begin
        if (arvalid && arready_q) begin
          addr_d  = araddr;
          class_d = ar_class;
          cnt_d   = CNT_LOAD;
          state_d = IMEM_S_WAIT;
        end
      end

      IMEM_S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Error requests run the full latency but never strobe the store.
          mem_r_en = resp_is_okay(class_q);
          rdata_d  = resp_is_okay(class_q) ? mem_r_data : '0;
          rresp_d  = class_q;
          rvalid_d = 1'b1;
          state_d  = IMEM_S_RESP;
        end
      end

      IMEM_S_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IMEM_S_IDLE;
        end
      end

      default: begin
        state_d = IMEM_S_IDLE;
      end
    endcase

    // Registered so arready stays low through reset and rises on the first
    // edge after release, and again on the edge that completes the R beat.
    arready_d = (state_d == IMEM_S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IMEM_S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      class_q   <= AXI_RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      class_q   <= class_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  assign arready  = arready_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign rvalid   = rvalid_q;
  assign mem_addr = addr_q;

endmodule

// File: doc/axi_lite_imem_slave.md
Name: axi_lite_imem_slave

Overview:
- AXI4-Lite read-channel responder (slave) answering the AXI instruction-fetch initiator.
- Accepts one read address at a time and waits a programmable number of cycles to emulate memory latency.
- Reads the 32-bit instruction word from a backing-store port, then returns it with an AXI response code.
- Sits between the fetch unit's AXI master port and physical memory (simulation backing store or SRAM macro).

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, read data width (one instruction)
- LATENCY, 1, cycles from AR handshake edge to RVALID rise; legal range 1..255
- MEM_BASE, 32'h8000_0000, first decodable byte address
- MEM_SIZE, 32'h0800_0000, decodable window size in bytes

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- mem_r_en  out  1  backing-store read strobe, one cycle
- mem_addr  out  ADDR_W  backing-store byte address (latched araddr)
- mem_r_data  in  DATA_W  backing-store data, combinational in the mem_r_en cycle

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, arready=0, rvalid=0, rdata=0, rresp=00, mem_r_en=0, cnt=0, addr latch=0.
  - arready rises on the first clk edge after rst deasserts.
- States:
  - IDLE: arready=1. On arvalid&arready: latch araddr, latch the error class, cnt<=LATENCY-1, go to WAIT.
  - WAIT: arready=0. While cnt!=0, cnt decrements each cycle.
  - When cnt==0: mem_r_en=1 combinationally, but only if the error class is OKAY. At that edge rdata<=mem_r_data (or 0 on error), rresp<=class, rvalid<=1, go to RESP.
  - RESP: rvalid=1. rdata and rresp are held stable until rready. On rvalid&rready go to IDLE and rvalid<=0.
- Timing:
  - AR handshake at edge E gives rvalid high after edge E+LATENCY.
  - With rready tied high, consecutive accepts are LATENCY+2 cycles apart.
- Error classification (computed at AR handshake):
  - araddr[1:0]!=0 -> SLVERR.
  - Else araddr outside [MEM_BASE, MEM_BASE+MEM_SIZE) -> DECERR.
  - Else OKAY.
  - Error responses consume full LATENCY, and mem_r_en is never asserted for them.
  - The window compare is done in ADDR_W+1 bits so MEM_BASE+MEM_SIZE cannot wrap.
- Handshake rules:
  - arvalid held while arready=0 is not accepted and causes no side effect.
  - araddr changing while unaccepted is ignored.
  - rvalid is never deasserted without rready.
  - rready high before rvalid has no effect.
- Simultaneous events: arvalid asserted in the same cycle as the R handshake is not accepted until IDLE (arready=0 in RESP).
- Reset mid-operation: pending request dropped, no R beat issued, outputs return to reset values immediately.
- mem_addr always equals the latched address, and is stable for the whole WAIT/RESP period.

Decomposition:
- Shared defines in the common header:
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR 2-bit codes.
  - State encodings IMEM_S_IDLE/WAIT/RESP (2-bit).
  - Default MEM_BASE/MEM_SIZE.
- Single module; no sub-module is natural (the latency counter is 8 bits inline).

Test Plan:
- LATENCY=1, araddr=32'h8000_0000, mem_r_data=32'h0000_0413, rready=1 -> rvalid one cycle after handshake, rdata=32'h0000_0413, rresp=00, mem_r_en pulses exactly once with mem_addr=32'h8000_0000.
- LATENCY=5, rready held low for 3 cycles after rvalid -> rvalid first high 5 cycles after handshake, rdata/rresp stable while stalled, arready=0 until the cycle after the rready handshake.
- araddr=32'h8000_0002 -> rresp=10, rdata=0, mem_r_en never asserted; araddr=32'h7FFF_FFFC -> rresp=11, rdata=0.
- Boundary: araddr=MEM_BASE+MEM_SIZE-4 -> OKAY; araddr=MEM_BASE+MEM_SIZE -> DECERR.
- rst pulled low in WAIT with cnt=2 -> rvalid stays 0, no mem_r_en; after release a new request at 32'h8000_0010 completes normally with OKAY.
- Back-to-back stream, arvalid held high, 4 sequential addresses, LATENCY=2, rready=1 -> 4 responses in order with matching data, accepts spaced 4 cycles apart, no dropped or duplicated beat.
